// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation and immediate-format enums.
// Used by decode_stage and imm_gen.
package riscv_pkg;

   localparam int REG_AW = 5;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] FUNCT7_BASE  = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT   = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SLT    = 4'd3,
      ALU_SLTU   = 4'd4,
      ALU_XOR    = 4'd5,
      ALU_SRL    = 4'd6,
      ALU_SRA    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

   typedef struct packed {
      logic     rs1_used;
      logic     rs2_used;
      logic     reg_write;
      logic     mem_read;
      logic     mem_write;
      logic     branch;
      logic     jump;
      logic     src_b_imm;
      logic     illegal;
      alu_op_e  alu_op;
      imm_fmt_e fmt;
   } dec_ctrl_t;

   // alt selects SUB/SRA (instr[30]); callers pass 0 where bit 30 is immediate data
   function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
      alu_op_e op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; the format select comes from the decoder.
// Only instruction bits [31:7] carry immediate data.
module imm_gen
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:7]     i_instr,
   input  imm_fmt_e        i_fmt,
   output logic [XLEN-1:0] o_imm
);

   logic [31:0] w_imm32;

   always_comb begin
      case (i_fmt)
         IMM_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
         IMM_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase
      // widen to XLEN by replicating the sign, then drop in the 32-bit value
      o_imm       = {XLEN{w_imm32[31]}};
      o_imm[31:0] = w_imm32;
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with register-file read issue, busy scoreboard and one pipeline register.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds the registered ex_illegal output.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [31:0]       if_instr,
   input  logic [XLEN-1:0]   if_pc,
   output logic              rf_read_en,
   output logic [REG_AW-1:0] rf_raddr1,
   output logic [REG_AW-1:0] rf_raddr2,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rd,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [2:0]        ex_funct3,
   output alu_op_e           ex_alu_op,
   output logic              ex_src_b_imm,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic              ex_jump,
`ifdef DECODE_ILLEGAL_TRAP_EN
   output logic              ex_illegal,
`endif
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic              flush
);

   logic [6:0]        w_opcode;
   logic [REG_AW-1:0] w_rd;
   logic [REG_AW-1:0] w_rs1;
   logic [REG_AW-1:0] w_rs2;
   logic [2:0]        w_funct3;
   logic [6:0]        w_funct7;
   dec_ctrl_t         w_ctrl;
   logic [XLEN-1:0]   w_imm;
   logic              w_hazard;
   logic              w_accept;
   logic              w_flush_kill;
   logic [NREGS-1:0]  w_busy_next;
   logic [NREGS-1:1]  w_set;
   logic [NREGS-1:1]  w_clr;

   logic [NREGS-1:0]  r_busy;
   logic              r_ex_valid;
   logic [XLEN-1:0]   r_ex_pc;
   logic [XLEN-1:0]   r_ex_imm;
   logic [REG_AW-1:0] r_ex_rd;
   logic [REG_AW-1:0] r_ex_rs1;
   logic [REG_AW-1:0] r_ex_rs2;
   logic [2:0]        r_ex_funct3;
   alu_op_e           r_ex_alu_op;
   logic              r_ex_src_b_imm;
   logic              r_ex_reg_write;
   logic              r_ex_mem_read;
   logic              r_ex_mem_write;
   logic              r_ex_branch;
   logic              r_ex_jump;
   logic              r_ex_illegal;

   assign w_opcode = if_instr[6:0];
   assign w_rd     = if_instr[11:7];
   assign w_funct3 = if_instr[14:12];
   assign w_rs1    = if_instr[19:15];
   assign w_rs2    = if_instr[24:20];
   assign w_funct7 = if_instr[31:25];

   always_comb begin
      w_ctrl        = '0;
      w_ctrl.alu_op = ALU_ADD;
      w_ctrl.fmt    = IMM_NONE;
      case (w_opcode)
         OPC_LUI: begin
            w_ctrl.reg_write = 1'b1; w_ctrl.src_b_imm = 1'b1;
            w_ctrl.alu_op    = ALU_PASS_B; w_ctrl.fmt = IMM_U;
         end
         OPC_AUIPC: begin
            w_ctrl.reg_write = 1'b1; w_ctrl.src_b_imm = 1'b1; w_ctrl.fmt = IMM_U;
         end
         OPC_JAL: begin
            w_ctrl.reg_write = 1'b1; w_ctrl.jump = 1'b1;
            w_ctrl.src_b_imm = 1'b1; w_ctrl.fmt  = IMM_J;
         end
         OPC_JALR: begin
            w_ctrl.rs1_used  = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.jump = 1'b1;
            w_ctrl.src_b_imm = 1'b1; w_ctrl.fmt       = IMM_I;
         end
         OPC_BRANCH: begin
            w_ctrl.rs1_used = 1'b1; w_ctrl.rs2_used = 1'b1; w_ctrl.branch = 1'b1;
            w_ctrl.alu_op   = ALU_SUB; w_ctrl.fmt   = IMM_B;
         end
         OPC_LOAD: begin
            w_ctrl.rs1_used  = 1'b1; w_ctrl.reg_write = 1'b1; w_ctrl.mem_read = 1'b1;
            w_ctrl.src_b_imm = 1'b1; w_ctrl.fmt       = IMM_I;
         end
         OPC_STORE: begin
            w_ctrl.rs1_used  = 1'b1; w_ctrl.rs2_used = 1'b1; w_ctrl.mem_write = 1'b1;
            w_ctrl.src_b_imm = 1'b1; w_ctrl.fmt      = IMM_S;
         end
         OPC_OP_IMM: begin
            w_ctrl.rs1_used  = 1'b1; w_ctrl.reg_write = 1'b1;
            w_ctrl.src_b_imm = 1'b1; w_ctrl.fmt       = IMM_I;
            w_ctrl.alu_op    = alu_from_funct3(w_funct3, (w_funct3 == 3'b101) && if_instr[30]);
            if (w_funct3 == 3'b001)
               w_ctrl.illegal = (w_funct7 != FUNCT7_BASE);
            else if (w_funct3 == 3'b101)
               w_ctrl.illegal = (w_funct7 != FUNCT7_BASE) && (w_funct7 != FUNCT7_ALT);
         end
         OPC_OP: begin
            w_ctrl.rs1_used  = 1'b1; w_ctrl.rs2_used = 1'b1; w_ctrl.reg_write = 1'b1;
            w_ctrl.alu_op    = alu_from_funct3(w_funct3, if_instr[30]);
            w_ctrl.illegal   = !((w_funct7 == FUNCT7_BASE) ||
                                 ((w_funct7 == FUNCT7_ALT) &&
                                  ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
         end
         OPC_MISC_MEM, OPC_SYSTEM: ;
         default: w_ctrl.illegal = 1'b1;
      endcase
      // an illegal encoding must not write, touch memory, redirect, or stall on operands
      if (w_ctrl.illegal) begin
         w_ctrl.rs1_used  = 1'b0; w_ctrl.rs2_used  = 1'b0; w_ctrl.reg_write = 1'b0;
         w_ctrl.mem_read  = 1'b0; w_ctrl.mem_write = 1'b0;
         w_ctrl.branch    = 1'b0; w_ctrl.jump      = 1'b0;
      end
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .i_instr (if_instr[31:7]),
      .i_fmt   (w_ctrl.fmt),
      .o_imm   (w_imm)
   );

   assign w_hazard = (w_ctrl.rs1_used && r_busy[w_rs1]) ||
                     (w_ctrl.rs2_used && r_busy[w_rs2]) ||
                     (w_ctrl.reg_write && (w_rd != '0) && r_busy[w_rd]);

   assign if_ready   = rst_n && !flush && !w_hazard && (!r_ex_valid || ex_ready);
   assign w_accept   = if_valid && if_ready;
   assign rf_read_en = w_accept;
   assign rf_raddr1  = w_rs1;
   assign rf_raddr2  = w_rs2;

   assign w_flush_kill = flush && r_ex_valid && r_ex_reg_write;

   // set beats clear so a retiring write and a new writer to the same reg keep it busy
   genvar gi;
   generate
      for (gi = 1; gi < NREGS; gi++) begin : g_busy
         assign w_set[gi] = w_accept && w_ctrl.reg_write && (w_rd == REG_AW'(gi));
         assign w_clr[gi] = (wb_valid && (wb_addr == REG_AW'(gi))) ||
                            (w_flush_kill && (r_ex_rd == REG_AW'(gi)));
         assign w_busy_next[gi] = w_set[gi] || (r_busy[gi] && !w_clr[gi]);
      end
   endgenerate
   assign w_busy_next[0] = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy         <= '0;
         r_ex_valid     <= 1'b0;
         r_ex_pc        <= '0;
         r_ex_imm       <= '0;
         r_ex_rd        <= '0;
         r_ex_rs1       <= '0;
         r_ex_rs2       <= '0;
         r_ex_funct3    <= '0;
         r_ex_alu_op    <= ALU_ADD;
         r_ex_src_b_imm <= 1'b0;
         r_ex_reg_write <= 1'b0;
         r_ex_mem_read  <= 1'b0;
         r_ex_mem_write <= 1'b0;
         r_ex_branch    <= 1'b0;
         r_ex_jump      <= 1'b0;
         r_ex_illegal   <= 1'b0;
      end else begin
         r_busy <= w_busy_next;
         if (flush)
            r_ex_valid <= 1'b0;
         else if (w_accept)
            r_ex_valid <= 1'b1;
         else if (ex_ready)
            r_ex_valid <= 1'b0;
         if (w_accept) begin
            r_ex_pc        <= if_pc;
            r_ex_imm       <= w_imm;
            r_ex_rd        <= w_rd;
            r_ex_rs1       <= w_rs1;
            r_ex_rs2       <= w_rs2;
            r_ex_funct3    <= w_funct3;
            r_ex_alu_op    <= w_ctrl.alu_op;
            r_ex_src_b_imm <= w_ctrl.src_b_imm;
            r_ex_reg_write <= w_ctrl.reg_write;
            r_ex_mem_read  <= w_ctrl.mem_read;
            r_ex_mem_write <= w_ctrl.mem_write;
            r_ex_branch    <= w_ctrl.branch;
            r_ex_jump      <= w_ctrl.jump;
            r_ex_illegal   <= w_ctrl.illegal;
         end
      end
   end

   assign ex_valid     = r_ex_valid;
   assign ex_pc        = r_ex_pc;
   assign ex_imm       = r_ex_imm;
   assign ex_rd        = r_ex_rd;
   assign ex_rs1       = r_ex_rs1;
   assign ex_rs2       = r_ex_rs2;
   assign ex_funct3    = r_ex_funct3;
   assign ex_alu_op    = r_ex_alu_op;
   assign ex_src_b_imm = r_ex_src_b_imm;
   assign ex_reg_write = r_ex_reg_write;
   assign ex_mem_read  = r_ex_mem_read;
   assign ex_mem_write = r_ex_mem_write;
   assign ex_branch    = r_ex_branch;
   assign ex_jump      = r_ex_jump;

`ifdef DECODE_ILLEGAL_TRAP_EN
   assign ex_illegal = r_ex_illegal;
`else
   logic w_illegal_unused;
   assign w_illegal_unused = r_ex_illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected ex_* records, a negedge
// monitor pops one each time a freshly accepted instruction appears in the pipeline register.
module tb_decode_stage;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        rf_read_en;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc, ex_imm;
   logic [4:0]  ex_rd, ex_rs1, ex_rs2;
   logic [2:0]  ex_funct3;
   alu_op_e     ex_alu_op;
   logic        ex_src_b_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic        flush;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic        ex_illegal;
`endif

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_PASS = 4'd10;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [3:0]  alu;
      logic        srcb, rw, mr, mw, br, jp;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   pending  = 1'b0;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .NREGS(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_valid     (if_valid),
      .if_ready     (if_ready),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .rf_read_en   (rf_read_en),
      .rf_raddr1    (rf_raddr1),
      .rf_raddr2    (rf_raddr2),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_pc        (ex_pc),
      .ex_imm       (ex_imm),
      .ex_rd        (ex_rd),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .ex_funct3    (ex_funct3),
      .ex_alu_op    (ex_alu_op),
      .ex_src_b_imm (ex_src_b_imm),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_branch    (ex_branch),
      .ex_jump      (ex_jump),
`ifdef DECODE_ILLEGAL_TRAP_EN
      .ex_illegal   (ex_illegal),
`endif
      .wb_valid     (wb_valid),
      .wb_addr      (wb_addr),
      .flush        (flush)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end else
         $display("ok   %s = %h", name, act);
   endtask

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3, input logic [3:0] alu,
                               input logic srcb, input logic rw, input logic mr,
                               input logic mw, input logic br, input logic jp);
      exp_t e;
      e = '{pc: pc, imm: imm, rd: rd, rs1: rs1, rs2: rs2, f3: f3, alu: alu,
            srcb: srcb, rw: rw, mr: mr, mw: mw, br: br, jp: jp};
      return e;
   endfunction

   task automatic present(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
      exp_q.push_back(e);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // monitor: the cycle after an accept, ex_* must show that instruction
   always @(negedge clk) begin
      exp_t act, e;
      if (!rst_n)
         pending = 1'b0;
      else begin
         if (pending) begin
            act = '{pc: ex_pc, imm: ex_imm, rd: ex_rd, rs1: ex_rs1, rs2: ex_rs2,
                    f3: ex_funct3, alu: ex_alu_op, srcb: ex_src_b_imm, rw: ex_reg_write,
                    mr: ex_mem_read, mw: ex_mem_write, br: ex_branch, jp: ex_jump};
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL ex_unexpected: got pc %h, expected no accept", ex_pc);
            end else begin
               e = exp_q.pop_front();
               if (!ex_valid || act !== e) begin
                  failures++;
                  $display("FAIL ex_fields: got valid=%b %h, expected valid=1 %h", ex_valid, act, e);
               end else
                  $display("ok   ex pc=%h imm=%h rd=%0d alu=%0d", ex_pc, ex_imm, ex_rd, ex_alu_op);
            end
         end
         pending = if_valid && if_ready;
      end
   end

   initial begin
      rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
      ex_ready = 1'b1; wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_if_ready",   32'(if_ready),   0);
      chk("rst_rf_read_en", 32'(rf_read_en), 0);
      chk("rst_ex_valid",   32'(ex_valid),   0);
      chk("rst_ex_imm",     ex_imm,          0);
      step(); rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_if_ready", 32'(if_ready), 1);

      // addi x5,x0,-1
      step();
      present(32'hFFF00293, 32'h100, mk(32'h100, 32'hFFFFFFFF, 5, 0, 31, 0, A_ADD, 1, 1, 0, 0, 0, 0));
      @(negedge clk);
      chk("addi_rf_read_en", 32'(rf_read_en), 1);
      chk("addi_raddr1",     32'(rf_raddr1),  0);
      chk("addi_raddr2",     32'(rf_raddr2),  31);

      // add x6,x5,x5: RAW on x5 until the cycle after writeback
      step();
      present(32'h00528333, 32'h104, mk(32'h104, 32'h0, 6, 5, 5, 0, A_ADD, 0, 1, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("raw_stall_ready", 32'(if_ready),   0);
         chk("raw_stall_rden",  32'(rf_read_en), 0);
         step();
      end
      wb_valid = 1'b1; wb_addr = 5'd5;
      @(negedge clk);
      chk("raw_wb_cycle_ready", 32'(if_ready), 0);
      step(); wb_valid = 1'b0;
      @(negedge clk);
      chk("raw_release_ready", 32'(if_ready),  1);
      chk("raw_raddr1",        32'(rf_raddr1), 5);

      // lui x7,0x12345 while execute stalls for 3 cycles
      step(); ex_ready = 1'b0;
      present(32'h123453B7, 32'h108, mk(32'h108, 32'h12345000, 7, 8, 3, 5, A_PASS, 1, 1, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_ready",   32'(if_ready),   0);
         chk("hold_rden",    32'(rf_read_en), 0);
         chk("hold_valid",   32'(ex_valid),   1);
         chk("hold_ex_rd",   32'(ex_rd),      6);
         chk("hold_ex_pc",   ex_pc,           32'h104);
         step();
      end
      ex_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_ready", 32'(if_ready), 1);

      // keep lui in ex, then flush it
      step(); if_valid = 1'b0; ex_ready = 1'b0;
      @(negedge clk);
      step(); flush = 1'b1;
      @(negedge clk);
      chk("flush_cycle_ready", 32'(if_ready), 0);
      step(); flush = 1'b0; ex_ready = 1'b1;
      // addi x8,x7,1: busy[7] must have been released by the flush
      present(32'h00138413, 32'h10C, mk(32'h10C, 32'h1, 8, 7, 1, 0, A_ADD, 1, 1, 0, 0, 0, 0));
      @(negedge clk);
      chk("flush_kill_valid", 32'(ex_valid), 0);
      chk("busy7_cleared",    32'(if_ready), 1);

      // addi x0,x0,5 then addi x1,x0,1: x0 never becomes busy
      step();
      present(32'h00500013, 32'h110, mk(32'h110, 32'h5, 0, 0, 5, 0, A_ADD, 1, 1, 0, 0, 0, 0));
      @(negedge clk);
      chk("x0_write_ready", 32'(if_ready), 1);
      step();
      present(32'h00100093, 32'h114, mk(32'h114, 32'h1, 1, 0, 1, 0, A_ADD, 1, 1, 0, 0, 0, 0));
      @(negedge clk);
      chk("x0_never_busy", 32'(if_ready), 1);

      // addi x9,x0,3 accepted in the same cycle as writeback of x9
      step(); wb_valid = 1'b1; wb_addr = 5'd9;
      present(32'h00300493, 32'h118, mk(32'h118, 32'h3, 9, 0, 3, 0, A_ADD, 1, 1, 0, 0, 0, 0));
      @(negedge clk);
      chk("x9_accept_ready", 32'(if_ready), 1);
      step(); wb_valid = 1'b0;
      present(32'h00048533, 32'h11C, mk(32'h11C, 32'h0, 10, 9, 0, 0, A_ADD, 0, 1, 0, 0, 0, 0));
      @(negedge clk);
      chk("set_wins_stall", 32'(if_ready), 0);
      step(); wb_valid = 1'b1; wb_addr = 5'd9;
      @(negedge clk);
      chk("x9_wb_cycle", 32'(if_ready), 0);
      step(); wb_valid = 1'b0;
      @(negedge clk);
      chk("x9_release", 32'(if_ready), 1);

      // jal x3,+0x800 held off by a flush for one cycle
      step(); flush = 1'b1;
      present(32'h001001EF, 32'h120, mk(32'h120, 32'h800, 3, 0, 1, 0, A_ADD, 1, 1, 0, 0, 0, 1));
      @(negedge clk);
      chk("flush_blocks_accept", 32'(if_ready), 0);
      step(); flush = 1'b0;
      @(negedge clk);
      chk("jal_ready", 32'(if_ready), 1);

      // sw x2,-4(x0) and beq x0,x0,-8: S and B immediates
      step();
      present(32'hFE202E23, 32'h124, mk(32'h124, 32'hFFFFFFFC, 28, 0, 2, 2, A_ADD, 1, 0, 0, 1, 0, 0));
      @(negedge clk);
      chk("sw_ready", 32'(if_ready), 1);
      step();
      present(32'hFE000CE3, 32'h128, mk(32'h128, 32'hFFFFFFF8, 25, 0, 0, 0, A_SUB, 0, 0, 0, 0, 1, 0));
      @(negedge clk);
      chk("beq_ready", 32'(if_ready), 1);

      // asynchronous reset while ex holds beq; x3/x8 busy bits must vanish
      step(); if_valid = 1'b0; ex_ready = 1'b0;
      @(negedge clk);
      chk("pre_reset_valid", 32'(ex_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(ex_valid),   0);
      chk("async_rst_ready", 32'(if_ready),   0);
      chk("async_rst_rden",  32'(rf_read_en), 0);
      chk("async_rst_imm",   ex_imm,          0);
      step(); rst_n = 1'b1; ex_ready = 1'b1;
      present(32'h003405B3, 32'h12C, mk(32'h12C, 32'h0, 11, 8, 3, 0, A_ADD, 0, 1, 0, 0, 0, 0));
      @(negedge clk);
      chk("busy_reset_ready", 32'(if_ready), 1);
      step(); if_valid = 1'b0;

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction decode stage, directly upstream of the register file.
- Accepts fetched instructions over a valid/ready handshake and drives the register file's synchronous read port (enable plus two addresses).
- Holds one decoded instruction in a pipeline register for execute. Register-file read data arrives the cycle after acceptance, aligned with ex_valid.
- A 32-entry busy scoreboard stalls on RAW/WAW hazards against in-flight writes. Writeback retires entries.

Parameters:
- XLEN, 32, datapath width for instruction, PC and immediate.
- NREGS, 32, architectural register count. Scoreboard depth is NREGS; register index width is 5.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch holds a valid instruction
- if_ready  out  1  decode accepts this cycle
- if_instr  in  32  instruction word
- if_pc  in  XLEN  PC of if_instr
- rf_read_en  out  1  register file read enable
- rf_raddr1  out  5  rs1 index (if_instr[19:15])
- rf_raddr2  out  5  rs2 index (if_instr[24:20])
- ex_valid  out  1  pipeline register holds a valid instruction
- ex_ready  in  1  execute consumes this cycle
- ex_pc  out  XLEN  registered PC
- ex_imm  out  XLEN  sign-extended immediate
- ex_rd / ex_rs1 / ex_rs2  out  5 each  register indices
- ex_funct3  out  3  funct3 field
- ex_alu_op  out  4  ALU operation code (package enum)
- ex_src_b_imm  out  1  ALU operand B comes from the immediate
- ex_reg_write / ex_mem_read / ex_mem_write / ex_branch / ex_jump  out  1 each  control bits
- wb_valid  in  1  writeback retires a register write
- wb_addr  in  5  retired destination register
- flush  in  1  kill the instruction held in decode (taken branch/jump)

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, every ex_* field=0, busy bitmap=0.
- While in reset: if_ready=0 and rf_read_en=0.
- Uses: rs1 is used by all opcodes except LUI, AUIPC, JAL. rs2 is used only by R-type, STORE, BRANCH. rd is written by all opcodes except STORE and BRANCH.
- hazard = (rs1 used and busy[rs1]) or (rs2 used and busy[rs2]) or (reg_write and rd!=0 and busy[rd]).
- busy[0] is constant 0.
- Hazard checks use the registered bitmap. A same-cycle wb_valid does not bypass, so the stall lasts one extra cycle.
- if_ready = rst_n and !flush and !hazard and (!ex_valid or ex_ready). This is combinational from if_instr and the bitmap.
- accept = if_valid and if_ready.
- rf_read_en = accept. rf_raddr1/2 are the combinational instruction fields. The register file holds its output when not enabled, so read data stays aligned while execute stalls.
- On accept, the pipeline register loads the decoded fields and ex_valid=1 on the next edge: one-cycle latency.
- If ex_valid and ex_ready and no accept, ex_valid=0. Fields hold their last values.
- Immediates per format:
  - I: instr[31:20], sign-extended.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All are sign-extended to XLEN.
- Scoreboard:
  - On accept with reg_write and rd!=0, set busy[rd].
  - On wb_valid with wb_addr!=0, clear busy[wb_addr].
  - If set and clear hit the same index in one cycle, set wins.
- flush:
  - Forces ex_valid=0 and blocks accept that cycle.
  - If ex_valid and ex_reg_write and ex_rd!=0, clears busy[ex_rd]. WAW stalling guarantees no older writer shares that rd.
  - Clears from both flush and wb on the same index are idempotent.
- Unrecognised opcodes decode as a NOP: reg_write=0, no memory, no branch.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output ex_illegal (1 bit, reset 0).
  - Registered high for any opcode outside the RV32I set, or a bad funct3/funct7 on OP/OP-IMM shifts.
  - An illegal instruction sets no busy bit.
- Undefined: port absent; unrecognised opcodes become silent NOPs.

Decomposition:
- Shared package riscv_pkg holds the opcode localparams, the alu_op enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B) and the immediate-format enum.
- One sub-module, imm_gen: combinational, instr in, format select in, XLEN immediate out.
- The scoreboard stays inline.

Test Plan:
- Reset mid-stream: drive rst_n low with ex_valid=1 -> ex_valid=0, busy=0, if_ready=0 immediately; after release, if_ready=1.
- addi x5,x0,-1 (0xFFF00293) accepted -> rf_read_en=1, rf_raddr1=0; next cycle ex_valid=1, ex_imm=0xFFFFFFFF, ex_rd=5, busy[5]=1.
- RAW: add x6,x5,x5 immediately after -> if_ready=0 until cycle after wb_valid with wb_addr=5; then accepted.
- ex_ready=0 for 3 cycles with if_valid=1 -> ex fields stable, if_ready=0, no rf_read_en pulses.
- flush while ex holds lui x7 -> ex_valid=0 next cycle, busy[7] cleared; a write to x0 never sets busy[0].
- Same-cycle wb_valid(wb_addr=9) and accept of addi x9 -> busy[9]=1 after the edge.
